dm_arbiter: RTL and testbench

- Two-port arbiter that shares the single-port data memory between two requesters.
- Port 0 is the CPU load/store stage. Port 1 is the debug/loader DMA.
- The data memory reads combinationally and writes on the clock edge. This block issues at most one access per cycle, grants round-robin with a bounded burst, and returns read data registered one cycle after grant.

---
 rtl/dm_arbiter.sv | 136 +++++++++++++
 tb/tb_dm_arbiter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter.sv
// Two-port arbiter sharing one single-port data memory between the CPU
// load/store stage (port 0) and the debug/loader DMA (port 1).
module dm_arbiter #(
    parameter int WORD_WIDTH = 32,
    parameter int BURST_MAX  = 4
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [WORD_WIDTH-1:0] m0_addr,
    input  logic [WORD_WIDTH-1:0] m0_wdata,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [WORD_WIDTH-1:0] m0_rdata,

    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [WORD_WIDTH-1:0] m1_addr,
    input  logic [WORD_WIDTH-1:0] m1_wdata,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [WORD_WIDTH-1:0] m1_rdata,

    output logic [WORD_WIDTH-1:0] dm_addr,
    output logic [WORD_WIDTH-1:0] dm_wdata,
    output logic                  dm_write,
    output logic                  dm_read,
    input  logic [WORD_WIDTH-1:0] dm_rdata
);

    localparam logic [3:0] BURST_LIM = 4'(BURST_MAX);
    localparam logic [3:0] BURST_SAT = 4'hF;

    logic       owner_q, owner_d;
    logic       held_q, held_d;
    logic [3:0] burst_q, burst_d;

    logic       gnt_any;
    logic       gnt_port;
    logic       sel_we;
    logic [1:0] gnt_vec;
    logic [1:0] we_vec;

    // Grant decision: the owner keeps the memory only while it was granted
    // last cycle and has not yet used up its burst allowance.
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (!rst) begin
            if (m0_req && m1_req) begin
                if (held_q && (burst_q < BURST_LIM)) begin
                    m0_gnt = ~owner_q;
                    m1_gnt = owner_q;
                end else begin
                    m0_gnt = owner_q;
                    m1_gnt = ~owner_q;
                end
            end else begin
                m0_gnt = m0_req;
                m1_gnt = m1_req;
            end
        end
    end

    assign gnt_any  = m0_gnt | m1_gnt;
    assign gnt_port = m1_gnt;
    assign gnt_vec  = {m1_gnt, m0_gnt};
    assign we_vec   = {m1_we, m0_we};

    assign dm_addr  = m1_gnt ? m1_addr  : m0_addr;
    assign dm_wdata = m1_gnt ? m1_wdata : m0_wdata;
    assign sel_we   = m1_gnt ? m1_we    : m0_we;
    assign dm_write = gnt_any & sel_we;
    assign dm_read  = gnt_any & ~sel_we;

    always_comb begin
        owner_d = owner_q;
        held_d  = held_q;
        burst_d = burst_q;
        if (gnt_any) begin
            held_d = 1'b1;
            if ((gnt_port == owner_q) && held_q) begin
                burst_d = (burst_q == BURST_SAT) ? BURST_SAT : burst_q + 4'd1;
            end else begin
                owner_d = gnt_port;
                burst_d = 4'd1;
            end
        end else begin
            held_d  = 1'b0;
            burst_d = 4'd0;
        end
    end

    // owner resets to port 1 so that port 0 wins the first contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q <= 1'b1;
            held_q  <= 1'b0;
            burst_q <= 4'd0;
        end else begin
            owner_q <= owner_d;
            held_q  <= held_d;
            burst_q <= burst_d;
        end
    end

    // Per-port read return: capture memory data at the grant edge of a read.
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        logic                  rvalid_q, rvalid_d;
        logic [WORD_WIDTH-1:0] rdata_q, rdata_d;

        always_comb begin
            rvalid_d = gnt_vec[gi] & ~we_vec[gi];
            rdata_d  = rvalid_d ? dm_rdata : rdata_q;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                rvalid_q <= 1'b0;
                rdata_q  <= '0;
            end else begin
                rvalid_q <= rvalid_d;
                rdata_q  <= rdata_d;
            end
        end
    end

    // Masking with rst drops a read that is still in flight when reset hits.
    assign m0_rvalid = g_port[0].rvalid_q & ~rst;
    assign m0_rdata  = rst ? '0 : g_port[0].rdata_q;
    assign m1_rvalid = g_port[1].rvalid_q & ~rst;
    assign m1_rdata  = rst ? '0 : g_port[1].rdata_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter: vector table plus burst, streaming and reset sequences.
module tb_dm_arbiter;

    localparam logic [31:0] W5 = 32'h0000_5555;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        dm_write, dm_read;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dm_arbiter #(.WORD_WIDTH(32), .BURST_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_write(dm_write),
        .dm_read(dm_read), .dm_rdata(dm_rdata)
    );

    // Memory model: combinational read, write on the clock edge.
    logic [31:0] mem     [64];
    bit          written [64];
    logic [5:0]  mem_idx;
    assign mem_idx  = dm_addr[5:0];
    assign dm_rdata = written[mem_idx] ? mem[mem_idx]
                    : (mem_idx == 6'd5) ? 32'hDEAD_BEEF : (32'hA000_0000 | 32'(mem_idx));

    always @(posedge clk) begin
        if (dm_write) begin
            mem[mem_idx]     <= dm_wdata;
            written[mem_idx] <= 1'b1;
        end
    end

    typedef struct {
        logic        rst;
        logic        r0, w0;
        logic [31:0] a0, d0;
        logic        r1, w1;
        logic [31:0] a1, d1;
        logic        eg0, eg1, erd, ewr;
        logic [31:0] eaddr, ewdata;
        logic        ev0;
        logic [31:0] ed0;
        logic        ev1;
        logic [31:0] ed1;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic r0, input logic w0, input logic [31:0] a0,
                         input logic [31:0] d0, input logic r1, input logic w1,
                         input logic [31:0] a1, input logic [31:0] d1);
        rst = r;
        m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
    endtask

    // Inputs change just after the rising edge; outputs are sampled at the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] burst_exp [13];

        drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        repeat (2) @(posedge clk);
        #1;

        //             rst   r0   w0   a0      d0  r1   w1   a1      d1              g0   g1   rd   wr   addr    wdata           v0   d0              v1   d1
        vecs[0] = '{1'b1, 1'b1, 1'b0, 32'd5, W5, 1'b0, 1'b0, 32'd0, 32'd0,         1'b0, 1'b0, 1'b0, 1'b0, 32'd5, W5,           1'b0, 32'h0,          1'b0, 32'h0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 32'd5, W5, 1'b0, 1'b0, 32'd0, 32'd0,         1'b1, 1'b0, 1'b1, 1'b0, 32'd5, W5,           1'b0, 32'h0,          1'b0, 32'h0};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 32'd0, W5, 1'b1, 1'b1, 32'd9, 32'h12345678,  1'b0, 1'b1, 1'b0, 1'b1, 32'd9, 32'h12345678, 1'b1, 32'hDEADBEEF,   1'b0, 32'h0};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 32'd9, W5, 1'b0, 1'b0, 32'd0, 32'd0,         1'b1, 1'b0, 1'b1, 1'b0, 32'd9, W5,           1'b0, 32'hDEADBEEF,   1'b0, 32'h0};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 32'd0, W5, 1'b0, 1'b0, 32'd0, 32'd0,         1'b0, 1'b0, 1'b0, 1'b0, 32'd0, W5,           1'b1, 32'h12345678,   1'b0, 32'h0};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 32'd0, W5, 1'b1, 1'b0, 32'd7, 32'd0,         1'b0, 1'b1, 1'b1, 1'b0, 32'd7, 32'd0,        1'b0, 32'h12345678,   1'b0, 32'h0};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 32'd3, W5, 1'b1, 1'b0, 32'd8, 32'd0,         1'b0, 1'b1, 1'b1, 1'b0, 32'd8, 32'd0,        1'b0, 32'h12345678,   1'b1, 32'hA0000007};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 32'd0, W5, 1'b0, 1'b0, 32'd0, 32'd0,         1'b0, 1'b0, 1'b0, 1'b0, 32'd0, W5,           1'b0, 32'h12345678,   1'b1, 32'hA0000008};
        vecs[8] = '{1'b0, 1'b1, 1'b0, 32'd3, W5, 1'b1, 1'b0, 32'd8, 32'd0,         1'b1, 1'b0, 1'b1, 1'b0, 32'd3, W5,           1'b0, 32'h12345678,   1'b0, 32'hA0000008};
        vecs[9] = '{1'b0, 1'b0, 1'b0, 32'd0, W5, 1'b0, 1'b0, 32'd0, 32'd0,         1'b0, 1'b0, 1'b0, 1'b0, 32'd0, W5,           1'b1, 32'hA0000003,   1'b0, 32'hA0000008};

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].r0, vecs[i].w0, vecs[i].a0, vecs[i].d0,
                  vecs[i].r1, vecs[i].w1, vecs[i].a1, vecs[i].d1);
            @(negedge clk);
            chk($sformatf("v%0d m0_gnt", i),    32'(m0_gnt),    32'(vecs[i].eg0));
            chk($sformatf("v%0d m1_gnt", i),    32'(m1_gnt),    32'(vecs[i].eg1));
            chk($sformatf("v%0d dm_read", i),   32'(dm_read),   32'(vecs[i].erd));
            chk($sformatf("v%0d dm_write", i),  32'(dm_write),  32'(vecs[i].ewr));
            chk($sformatf("v%0d dm_addr", i),   dm_addr,        vecs[i].eaddr);
            chk($sformatf("v%0d dm_wdata", i),  dm_wdata,       vecs[i].ewdata);
            chk($sformatf("v%0d m0_rvalid", i), 32'(m0_rvalid), 32'(vecs[i].ev0));
            chk($sformatf("v%0d m0_rdata", i),  m0_rdata,       vecs[i].ed0);
            chk($sformatf("v%0d m1_rvalid", i), 32'(m1_rvalid), 32'(vecs[i].ev1));
            chk($sformatf("v%0d m1_rdata", i),  m1_rdata,       vecs[i].ed1);
            $display("vector %0d: gnt=%b%b dm_addr=%h m0 rv=%b rd=%h m1 rv=%b rd=%h",
                     i, m0_gnt, m1_gnt, dm_addr, m0_rvalid, m0_rdata, m1_rvalid, m1_rdata);
            next_cycle();
        end

        // Burst limit: m0 alone for 3 grants, then both contend continuously.
        // 2'b01 = m0 granted, 2'b10 = m1 granted.
        burst_exp = '{2'b01, 2'b01, 2'b01,
                      2'b01, 2'b10, 2'b10, 2'b10, 2'b10,
                      2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
        for (int c = 0; c < 13; c++) begin
            drive(1'b0, 1'b1, 1'b0, 32'd1, W5, (c >= 3), 1'b0, 32'd2, 32'd0);
            @(negedge clk);
            chk($sformatf("burst c%0d gnt", c), 32'({m1_gnt, m0_gnt}), 32'(burst_exp[c]));
            $display("burst cycle %0d: m0_gnt=%b m1_gnt=%b", c, m0_gnt, m1_gnt);
            next_cycle();
        end

        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        next_cycle();

        // m1 alone streams 20 reads: continuous grant and continuous rvalid.
        for (int c = 0; c <= 21; c++) begin
            drive(1'b0, 1'b0, 1'b0, '0, '0, (c < 20), 1'b0, 32'(10 + c), 32'd0);
            @(negedge clk);
            chk($sformatf("stream c%0d m1_gnt", c), 32'(m1_gnt), 32'(c < 20));
            if (c >= 1 && c <= 20) begin
                chk($sformatf("stream c%0d m1_rvalid", c), 32'(m1_rvalid), 32'd1);
                chk($sformatf("stream c%0d m1_rdata", c), m1_rdata, 32'hA000_0000 + 32'(10 + c - 1));
            end else if (c == 21) begin
                chk("stream end m1_rvalid", 32'(m1_rvalid), 32'd0);
                chk("stream end m1_rdata hold", m1_rdata, 32'hA000_001D);
            end
            $display("stream cycle %0d: m1_gnt=%b m1_rvalid=%b m1_rdata=%h", c, m1_gnt, m1_rvalid, m1_rdata);
            next_cycle();
        end

        // Reset right after a granted read drops the returning word.
        drive(1'b0, 1'b1, 1'b0, 32'd5, W5, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk("rst pre m0_gnt", 32'(m0_gnt), 32'd1);
        $display("reset seq grant: m0_gnt=%b dm_read=%b", m0_gnt, dm_read);
        next_cycle();
        drive(1'b1, 1'b1, 1'b0, 32'd5, W5, 1'b1, 1'b0, 32'd6, 32'd0);
        @(negedge clk);
        chk("rst m0_rvalid", 32'(m0_rvalid), 32'd0);
        chk("rst m0_rdata",  m0_rdata,       32'd0);
        chk("rst gnt",       32'({m1_gnt, m0_gnt}), 32'd0);
        chk("rst dm_strobes", 32'({dm_write, dm_read}), 32'd0);
        $display("reset seq in reset: m0_rvalid=%b m0_rdata=%h gnt=%b%b", m0_rvalid, m0_rdata, m0_gnt, m1_gnt);
        next_cycle();
        drive(1'b0, 1'b1, 1'b0, 32'd5, W5, 1'b1, 1'b0, 32'd6, 32'd0);
        @(negedge clk);
        chk("post-rst gnt", 32'({m1_gnt, m0_gnt}), 32'b01);
        chk("post-rst m0_rvalid", 32'(m0_rvalid), 32'd0);
        $display("reset seq release: m0_gnt=%b m1_gnt=%b", m0_gnt, m1_gnt);
        next_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
